dfcnq_pipe: RTL and testbench
=============================

Name: dfcnq_pipe

Overview:
Parametrised pipeline register built on the clear-able D flop, the DFCNQD1 type: clock on cp, async active-low clear on cdn.
- Extends the single flop to WIDTH bits by DEPTH stages.
- Adds a valid/ready handshake with bubble collapsing and a full-block scan chain.
- Used as the standard retiming and elastic buffer between synthesised blocks in the cell-library flow.

Parameters:
WIDTH, 8, data bits per stage (>=1)
DEPTH, 4, number of pipeline stages (>=1)
RESET_VAL, {WIDTH{1'b0}}, value loaded into every stage data register on clear

Ports:
cp  in  1  clock, rising edge active
cdn  in  1  asynchronous active-low clear
se  in  1  scan enable
si  in  1  scan serial in
so  out  1  scan serial out
in_valid  in  1  upstream word present on d
in_ready  out  1  block accepts d this cycle
d  in  WIDTH  upstream data
out_valid  out  1  q holds a valid word
out_ready  in  1  downstream accepts q this cycle
q  out  WIDTH  output data, which is stage DEPTH-1
occ  out  $clog2(DEPTH+1)  number of valid stages

Behaviour:
Interface and reset:
- One clock (cp). Reset cdn is asynchronous and active-low.
- cdn=0 clears immediately, without waiting for a cp edge:
  - all vld[k]=0 and all dat[k]=RESET_VAL;
  - out_valid=0, q=RESET_VAL, occ=0;
  - so=RESET_VAL[WIDTH-1];
  - in_ready reflects an empty pipe (1 when se=0).
- Clear release is synchronous to the next cp edge, which is the first active edge.

Normal mode (se=0):
- Each stage k holds vld[k] and dat[k]. Stage 0 is the input side; stage DEPTH-1 drives q and out_valid.
- Advance rule:
  - adv[DEPTH-1] = vld[DEPTH-1] & out_ready.
  - For k<DEPTH-1: adv[k] = vld[k] & (!vld[k+1] | adv[k+1]).
- in_ready = !vld[0] | adv[0]. This is a combinational ready chain and contains no registered skid.
- Transfers:
  - A beat is accepted on an edge where in_valid & in_ready.
  - A beat is delivered on an edge where out_valid & out_ready.
- At each edge:
  - stage k+1 takes dat[k] when adv[k];
  - stage 0 takes d when accepted;
  - vld[k] = (incoming beat) | (vld[k] & !adv[k]).
- Data registers are written only when they receive a beat. Invalid stages keep stale data; q is undefined-by-protocol when out_valid=0 but equals dat[DEPTH-1].
- Latency: a beat accepted at edge t is valid on q after edge t+DEPTH-1, when the stages ahead are empty. DEPTH=1 gives q valid right after the accept edge.
- Throughput: 1 beat/cycle when out_ready is held high.
- Bubble collapsing: an invalid stage is always filled if the stage behind it is valid, regardless of out_ready.
- Full (occ=DEPTH):
  - out_ready=1 gives in_ready=1, with simultaneous push and pop.
  - out_ready=0 gives in_ready=0.
- Empty: out_valid=0, and in_ready=1.
- Ordering is strict FIFO; no beat is dropped or duplicated.
- occ is the popcount of vld[], combinational from registers.

Scan mode (se=1):
- in_ready=0 and out_valid=0, forced. No handshake completes on any edge with se=1.
- All DEPTH*(WIDTH+1) flops form one chain, shifting one position per cp edge, in this order:
  - si, then vld[0], then dat[0][0..WIDTH-1];
  - then vld[1], dat[1][0..WIDTH-1], and so on up to dat[DEPTH-1][WIDTH-1];
  - then so.
- so = dat[DEPTH-1][WIDTH-1] directly from the flop, with no combinational path from si.
- se toggling takes effect on the same cycle's edge. On the edge after se falls, the pipeline resumes from the scanned vld/dat contents.
- cdn=0 overrides scan and clears the whole chain.

Test Plan:
1. Reset: WIDTH=8, DEPTH=4, RESET_VAL=8'h5A. Pipe full with data, then cdn=0 between edges -> out_valid=0, q=8'h5A, occ=0, so=0 immediately; first post-release edge accepts a word.
2. Streaming: out_ready=1, d=8'h01..8'h10 one per cycle -> 8'h01 on q 3 edges after acceptance, then one word per cycle in order, in_ready constantly 1.
3. Backpressure: out_ready=0, offer 6 words 8'hA0..8'hA5.
   - Expect 8'hA0..8'hA3 accepted, in_ready=0, occ=4.
   - Raise out_ready -> 8'hA4 and 8'hA5 accepted in the same cycles as the pops; output sequence 8'hA0..8'hA5 with no loss or duplicates.
4. Bubble collapse: out_ready=0; send 8'h11, idle 5 cycles, send 8'h22 -> 8'h11 in stage 3, 8'h22 collapses to stage 2 after 2 edges, occ=2, in_ready=1.
5. Scan: se=1, shift a 36-bit pattern 36'h9_A5C3_F00F over 36 edges.
   - in_ready=0 and out_valid=0 throughout.
   - Next 36 edges return the same pattern on so.
   - After a reload and se=0, q, out_valid and occ match the scanned vld/dat bits.
6. DEPTH=1, WIDTH=16: in_valid=1, out_ready=1, d incrementing from 16'h0000 -> q follows d delayed by one edge, in_ready=1 every cycle while full.

Source files
------------

// File: rtl/dfcnq_pipe.sv
// Elastic WIDTH x DEPTH pipeline of clear-able D flops with a valid/ready
// handshake, bubble collapsing and a single full-block scan chain.
module dfcnq_pipe #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       cp,
  input  logic                       cdn,
  input  logic                       se,
  input  logic                       si,
  output logic                       so,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           d,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           q,
  output logic [$clog2(DEPTH+1)-1:0] occ
);

  localparam int unsigned OW  = $clog2(DEPTH + 1);
  localparam int unsigned SW  = WIDTH + 1;
  localparam int unsigned NCH = DEPTH * SW;

  logic             vld     [DEPTH];
  logic [WIDTH-1:0] dat     [DEPTH];
  logic             vld_nxt [DEPTH];
  logic [WIDTH-1:0] dat_nxt [DEPTH];
  logic             adv     [DEPTH];
  logic             pipe_ready;
  logic             accept;
  logic [NCH-1:0]   chain;
  logic [NCH-1:0]   chain_sh;

  // Ready ripples from the output end; carry holds !vld[k] | adv[k] for the
  // stage just processed, so each stage sees the permission of the one ahead.
  always_comb begin : adv_chain
    logic carry;
    logic a;
    carry = out_ready;
    a     = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      a                 = vld[DEPTH-1-i] & carry;
      adv[DEPTH-1-i]    = a;
      carry             = !vld[DEPTH-1-i] | a;
    end
    pipe_ready = carry;
  end

  assign in_ready  = !se & pipe_ready;
  assign accept    = in_valid & in_ready;
  assign out_valid = !se & vld[DEPTH-1];
  assign q         = dat[DEPTH-1];
  assign so        = dat[DEPTH-1][WIDTH-1];

  // Flat scan view: stage k occupies bits k*SW (vld) .. k*SW+WIDTH (dat msb).
  always_comb begin
    chain = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      chain[k*SW]            = vld[k];
      chain[k*SW+1 +: WIDTH] = dat[k];
    end
  end

  assign chain_sh = {chain[NCH-2:0], si};

  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      vld_nxt[k] = vld[k];
      dat_nxt[k] = dat[k];
    end
    if (se) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        vld_nxt[k] = chain_sh[k*SW];
        dat_nxt[k] = chain_sh[k*SW+1 +: WIDTH];
      end
    end else begin
      vld_nxt[0] = accept | (vld[0] & !adv[0]);
      if (accept) dat_nxt[0] = d;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        vld_nxt[k] = adv[k-1] | (vld[k] & !adv[k]);
        if (adv[k-1]) dat_nxt[k] = dat[k-1];
      end
    end
  end

  always_ff @(posedge cp or negedge cdn) begin
    if (!cdn) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        vld[k] <= 1'b0;
        dat[k] <= RESET_VAL;
      end
    end else begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        vld[k] <= vld_nxt[k];
        dat[k] <= dat_nxt[k];
      end
    end
  end

  always_comb begin
    occ = '0;
    for (int unsigned k = 0; k < DEPTH; k++) occ = occ + OW'(vld[k]);
  end

endmodule

// File: tb/tb_dfcnq_pipe.sv
// Scoreboard bench for dfcnq_pipe: a 8x4 instance with RESET_VAL 8'h5A and
// a 16x1 instance, checked against queues of accepted beats.
module tb_dfcnq_pipe;

  logic        cp, cdn, se, si, so;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  d, q;
  logic [2:0]  occ;

  logic        se2, si2, so2;
  logic        in_valid2, in_ready2, out_valid2, out_ready2;
  logic [15:0] d2, q2;
  logic        occ2;

  int checks = 0;
  int errors = 0;
  logic [7:0]  sb  [$];
  logic [15:0] sb2 [$];

  dfcnq_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h5A)) u_dut (
    .cp(cp), .cdn(cdn), .se(se), .si(si), .so(so),
    .in_valid(in_valid), .in_ready(in_ready), .d(d),
    .out_valid(out_valid), .out_ready(out_ready), .q(q), .occ(occ)
  );

  dfcnq_pipe #(.WIDTH(16), .DEPTH(1), .RESET_VAL(16'h0000)) u_dut1 (
    .cp(cp), .cdn(cdn), .se(se2), .si(si2), .so(so2),
    .in_valid(in_valid2), .in_ready(in_ready2), .d(d2),
    .out_valid(out_valid2), .out_ready(out_ready2), .q(q2), .occ(occ2)
  );

  initial begin
    cp = 1'b0;
    forever #5 cp = ~cp;
  end

  task automatic fail(input string name, input logic [35:0] got, input logic [35:0] exp);
    errors++;
    $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // One cycle: drive after the falling edge, sample before the next rising edge.
  task automatic step(input logic v, input logic [7:0] dv, input logic r, output logic acc);
    logic [7:0] exp;
    @(negedge cp);
    in_valid = v; d = dv; out_ready = r;
    #1;
    checks++;
    if (int'(occ) !== sb.size()) fail("occ", 36'(occ), 36'(sb.size()));
    if (out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) fail("unexpected_beat", 36'(q), 36'h0);
      else begin
        exp = sb.pop_front();
        if (q !== exp) fail("q_order", 36'(q), 36'(exp));
      end
    end
    acc = in_valid && in_ready;
    if (acc) sb.push_back(d);
  endtask

  task automatic drain(input string name);
    logic a;
    int n = 0;
    while ((sb.size() != 0 || occ !== 3'd0) && n < 30) begin
      step(1'b0, 8'h00, 1'b1, a);
      n++;
    end
    checks++;
    if (sb.size() != 0 || occ !== 3'd0) fail(name, 36'(occ), 36'h0);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic a;
    #1;
    checks += 5;
    if (out_valid !== 1'b0) fail("rst_out_valid", 36'(out_valid), 36'h0);
    if (q !== 8'h5A)        fail("rst_q", 36'(q), 36'h5A);
    if (occ !== 3'd0)       fail("rst_occ", 36'(occ), 36'h0);
    if (so !== 1'b0)        fail("rst_so", 36'(so), 36'h0);
    if (in_ready !== 1'b1)  fail("rst_in_ready", 36'(in_ready), 36'h1);
    @(negedge cp); @(negedge cp);
    cdn = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, a);
    @(negedge cp);
    in_valid = 1'b0;
    checks++;
    if (occ !== 3'd4) fail("fill_occ", 36'(occ), 36'h4);
    #2 cdn = 1'b0;
    #1;
    checks += 4;
    if (out_valid !== 1'b0) fail("clr_out_valid", 36'(out_valid), 36'h0);
    if (q !== 8'h5A)        fail("clr_q", 36'(q), 36'h5A);
    if (occ !== 3'd0)       fail("clr_occ", 36'(occ), 36'h0);
    if (so !== 1'b0)        fail("clr_so", 36'(so), 36'h0);
    sb.delete();
    @(negedge cp);
    cdn = 1'b1;
    step(1'b1, 8'h77, 1'b1, a);
    checks++;
    if (a !== 1'b1) fail("post_release_accept", 36'(a), 36'h1);
    drain("rst_drain");
  endtask

  task automatic test_stream();
    logic a;
    int first = -1;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i + 1), 1'b1, a);
      checks++;
      if (a !== 1'b1) fail("stream_in_ready", 36'(a), 36'h1);
      if (out_valid && first < 0) first = i;
    end
    checks++;
    if (first != 4) fail("stream_latency", 36'(first), 36'h4);
    drain("stream_drain");
  endtask

  task automatic test_backpressure();
    logic a;
    int idx = 0;
    int n = 0;
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 8'(8'hA0 + idx), 1'b0, a);
      if (a) idx++;
    end
    checks += 3;
    if (idx != 4)          fail("bp_accepted", 36'(idx), 36'h4);
    if (in_ready !== 1'b0) fail("bp_in_ready", 36'(in_ready), 36'h0);
    if (occ !== 3'd4)      fail("bp_occ", 36'(occ), 36'h4);
    while (idx < 6 && n < 10) begin
      step(1'b1, 8'(8'hA0 + idx), 1'b1, a);
      checks++;
      if (a !== 1'b1) fail("bp_push_pop", 36'(a), 36'h1);
      if (a) idx++;
      n++;
    end
    drain("bp_drain");
  endtask

  task automatic test_bubble();
    logic a;
    step(1'b1, 8'h11, 1'b0, a);
    repeat (5) step(1'b0, 8'h00, 1'b0, a);
    checks += 2;
    if (out_valid !== 1'b1) fail("bub_out_valid", 36'(out_valid), 36'h1);
    if (q !== 8'h11)        fail("bub_q", 36'(q), 36'h11);
    step(1'b1, 8'h22, 1'b0, a);
    checks++;
    if (a !== 1'b1) fail("bub_accept", 36'(a), 36'h1);
    repeat (3) step(1'b0, 8'h00, 1'b0, a);
    checks += 5;
    if (occ !== 3'd2)            fail("bub_occ", 36'(occ), 36'h2);
    if (in_ready !== 1'b1)       fail("bub_in_ready", 36'(in_ready), 36'h1);
    if (u_dut.vld[2] !== 1'b1)   fail("bub_vld2", 36'(u_dut.vld[2]), 36'h1);
    if (u_dut.dat[2] !== 8'h22)  fail("bub_dat2", 36'(u_dut.dat[2]), 36'h22);
    if (u_dut.vld[1] !== 1'b0)   fail("bub_vld1", 36'(u_dut.vld[1]), 36'h0);
    drain("bub_drain");
  endtask

  task automatic test_scan();
    logic [35:0] pat;
    int pc;
    pat = 36'h9_A5C3_F00F;
    for (int i = 0; i < 36; i++) begin
      @(negedge cp);
      se = 1'b1; si = pat[35-i]; out_ready = 1'b1; in_valid = 1'b1;
      #1;
      checks += 2;
      if (in_ready !== 1'b0)  fail("scan_in_ready", 36'(in_ready), 36'h0);
      if (out_valid !== 1'b0) fail("scan_out_valid", 36'(out_valid), 36'h0);
    end
    for (int j = 0; j < 36; j++) begin
      @(negedge cp);
      si = pat[35-j];
      #1;
      checks += 2;
      if (so !== pat[35-j])   fail("scan_so", 36'(so), 36'(pat[35-j]));
      if (in_ready !== 1'b0)  fail("scan2_in_ready", 36'(in_ready), 36'h0);
    end
    @(negedge cp);
    se = 1'b0; in_valid = 1'b0;
    #1;
    pc = 0;
    for (int k = 0; k < 4; k++) if (pat[k*9]) pc++;
    checks += 3;
    if (q !== pat[35:28])      fail("scan_q", 36'(q), 36'(pat[35:28]));
    if (out_valid !== pat[27]) fail("scan_vld3", 36'(out_valid), 36'(pat[27]));
    if (int'(occ) !== pc)      fail("scan_occ", 36'(occ), 36'(pc));
    for (int k = 3; k >= 0; k--) if (pat[k*9]) sb.push_back(pat[k*9+1 +: 8]);
    drain("scan_drain");
  endtask

  task automatic test_depth1();
    logic [15:0] exp;
    for (int i = 0; i < 20; i++) begin
      @(negedge cp);
      in_valid2 = 1'b1; out_ready2 = 1'b1; d2 = 16'(i);
      #1;
      checks += 2;
      if (in_ready2 !== 1'b1)               fail("d1_in_ready", 36'(in_ready2), 36'h1);
      if (out_valid2 !== (i > 0 ? 1'b1 : 1'b0)) fail("d1_out_valid", 36'(out_valid2), 36'(i > 0));
      if (out_valid2 && out_ready2) begin
        checks++;
        if (sb2.size() == 0) fail("d1_unexpected", 36'(q2), 36'h0);
        else begin
          exp = sb2.pop_front();
          if (q2 !== exp) fail("d1_q", 36'(q2), 36'(exp));
        end
      end
      if (in_valid2 && in_ready2) sb2.push_back(d2);
    end
    @(negedge cp);
    in_valid2 = 1'b0;
    #1;
    checks++;
    if (q2 !== 16'd19) fail("d1_last_q", 36'(q2), 36'd19);
    void'(sb2.pop_front());
    @(negedge cp);
    #1;
    checks++;
    if (out_valid2 !== 1'b0 || sb2.size() != 0) fail("d1_empty", 36'(out_valid2), 36'h0);
  endtask

  initial begin
    cdn = 1'b1; se = 1'b0; si = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; d = '0;
    se2 = 1'b0; si2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b0; d2 = '0;
    #2 cdn = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_scan();
    test_depth1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
